// File: rtl/regfile_pkg.sv
// Shared encodings for the register file: write-size codes and sweep FSM states.
package regfile_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } wr_size_e;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_merge.sv
// Combinational write merge: folds byte/halfword/word write data into the old entry.
module regfile_merge
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] old_data,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [1:0]        wr_size,
    output logic [DATA_W-1:0] merged
);

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        merged = old_data;
        case (wr_size)
            SZ_BYTE: merged[7:0]  = wr_data[7:0];
            SZ_HALF: merged[15:0] = wr_data[15:0];
            SZ_WORD: merged       = wr_data;
            default: merged       = old_data;
        endcase
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with merged writes, same-cycle bypass,
// optional hard-wired zero register and a post-reset clear sweep.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     busy,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [1:0]               wr_size,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_e              state;
    logic [ADDR_W-1:0]   clr_idx;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   merged;
    logic                ready;
    logic                wr_zero;
    logic                wr_rsvd;
    logic                wr_valid;

    // rst is synchronous, so the state register lags it by one edge; gate on it directly.
    assign ready    = (state == READY) && !rst;
    assign busy     = !ready;
    assign wr_zero  = (ZERO_REG != 0) && (wr_addr == '0);
    assign wr_rsvd  = (wr_size == SZ_RSVD);
    assign wr_valid = ready && wr_en && !wr_rsvd && !wr_zero;

    regfile_merge #(.DATA_W(DATA_W)) u_merge (
        .old_data (mem[wr_addr]),
        .wr_data  (wr_data),
        .wr_size  (wr_size),
        .merged   (merged)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
            wr_err  <= 1'b0;
        end else begin
            wr_err <= (state == READY) && wr_en && wr_rsvd;
            if (state == CLEAR) begin
                clr_idx <= clr_idx + 1'b1;
                if (clr_idx == '1) state <= READY;
            end
        end
    end

    // NOTE: storage is deliberately not reset; the sweep zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst && state == CLEAR) mem[clr_idx] <= '0;
        else if (wr_valid)          mem[wr_addr] <= merged;
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] q;

        assign addr = rd_addr[i*ADDR_W +: ADDR_W];

        always_ff @(posedge clk) begin
            if (!ready) begin
                q <= '0;
            end else if (rd_en[i]) begin
                if ((ZERO_REG != 0) && addr == '0) q <= '0;
                else if (wr_valid && wr_addr == addr) q <= merged;
                else q <= mem[addr];
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = q;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios then random traffic
// compared against an array-based reference model.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             busy;
    logic [NR-1:0]    rd_en;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [1:0]       wr_size;
    logic [DW-1:0]    wr_data;
    logic             wr_err;

    int errors = 0;
    int checks = 0;

    logic [31:0] model  [DEPTH];
    logic [31:0] exp_rd [NR];
    logic        exp_err;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .busy    (busy),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_size (wr_size),
        .wr_data (wr_data),
        .wr_err  (wr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_port(input int p);
        return rd_data[p*DW +: DW];
    endfunction

    function automatic logic [31:0] merge_ref(input logic [31:0] old, input logic [31:0] nw,
                                              input logic [1:0] sz);
        case (sz)
            2'b00:   return (old & 32'hFFFF_FF00) | (nw & 32'h0000_00FF);
            2'b01:   return (old & 32'hFFFF_0000) | (nw & 32'h0000_FFFF);
            2'b10:   return nw;
            default: return old;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic en, input int addr, input logic [1:0] sz, input logic [31:0] d);
        wr_en   = en;
        wr_addr = AW'(addr);
        wr_size = sz;
        wr_data = d;
    endtask

    task automatic set_rd(input int p, input logic en, input int addr);
        rd_en[p]             = en;
        rd_addr[p*AW +: AW]  = AW'(addr);
    endtask

    // Predict one READY cycle from the current inputs, advance, compare.
    task automatic cycle(input string tag);
        logic        wv;
        logic [31:0] m;
        logic [AW-1:0] a;
        wv = wr_en && (wr_size != 2'b11) && (wr_addr != 0);
        m  = merge_ref(model[wr_addr], wr_data, wr_size);
        for (int p = 0; p < NR; p++) begin
            if (rd_en[p]) begin
                a = rd_addr[p*AW +: AW];
                if (a == 0)                    exp_rd[p] = 32'h0;
                else if (wv && wr_addr == a)   exp_rd[p] = m;
                else                           exp_rd[p] = model[a];
            end
        end
        exp_err = wr_en && (wr_size == 2'b11);
        if (wv) model[wr_addr] = m;
        step();
        for (int p = 0; p < NR; p++)
            check($sformatf("%s rd%0d", tag, p), rd_port(p), exp_rd[p]);
        check($sformatf("%s wr_err", tag), {31'b0, wr_err}, {31'b0, exp_err});
    endtask

    initial begin
        int n;
        rst = 1'b1;
        rd_en = '0;
        rd_addr = '0;
        set_wr(1'b0, 0, 2'b10, 32'h0);

        // Reset held for 3 cycles.
        repeat (3) step();
        check("reset busy", {31'b0, busy}, 32'd1);
        check("reset rd0", rd_port(0), 32'h0);
        check("reset rd1", rd_port(1), 32'h0);
        check("reset wr_err", {31'b0, wr_err}, 32'd0);

        // Release, run to sweep index 10, then re-assert reset.
        rst = 1'b0;
        repeat (10) step();
        check("mid-sweep busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        repeat (2) step();
        check("re-reset busy", {31'b0, busy}, 32'd1);
        rst = 1'b0;

        // busy must stay high for exactly DEPTH cycles after release.
        n = 0;
        while (busy && n < 200) begin
            n++;
            step();
        end
        check("sweep busy cycles", 32'(n), 32'(DEPTH));
        check("busy after sweep", {31'b0, busy}, 32'd0);

        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        for (int p = 0; p < NR; p++) exp_rd[p] = 32'h0;

        // Every entry reads zero after the sweep.
        for (int i = 0; i < DEPTH; i += 2) begin
            set_rd(0, 1'b1, i);
            set_rd(1, 1'b1, i + 1);
            cycle($sformatf("sweep read %0d", i));
            check("sweep zero p0", rd_port(0), 32'h0);
            check("sweep zero p1", rd_port(1), 32'h0);
        end
        rd_en = '0;

        // Byte and halfword merge on reg 5.
        set_wr(1'b1, 5, 2'b10, 32'hAABBCCDD); cycle("w5 word");
        set_wr(1'b1, 5, 2'b00, 32'h00000011); cycle("w5 byte");
        set_wr(1'b0, 0, 2'b10, 32'h0); set_rd(0, 1'b1, 5); cycle("r5 byte");
        check("byte merge", rd_port(0), 32'hAABBCC11);
        set_rd(0, 1'b0, 5);
        set_wr(1'b1, 5, 2'b01, 32'h00002233); cycle("w5 half");
        set_wr(1'b0, 0, 2'b10, 32'h0); set_rd(0, 1'b1, 5); cycle("r5 half");
        check("half merge", rd_port(0), 32'hAABB2233);

        // Same-cycle bypass on both ports.
        set_wr(1'b1, 9, 2'b10, 32'h12345678);
        set_rd(0, 1'b1, 9); set_rd(1, 1'b1, 9);
        cycle("bypass");
        check("bypass p0", rd_port(0), 32'h12345678);
        check("bypass p1", rd_port(1), 32'h12345678);
        rd_en = '0;

        // Zero register ignores writes and never bypasses.
        set_wr(1'b1, 0, 2'b10, 32'hFFFFFFFF); set_rd(0, 1'b1, 0);
        cycle("zero reg");
        check("zero reg read", rd_port(0), 32'h0);
        check("zero reg err", {31'b0, wr_err}, 32'd0);
        rd_en = '0;

        // Reserved size: one wr_err pulse per request, entry unchanged.
        set_wr(1'b1, 3, 2'b10, 32'hCAFEF00D); cycle("w3 word");
        set_wr(1'b1, 3, 2'b11, 32'hDEADBEEF); cycle("rsvd 1");
        check("rsvd pulse 1", {31'b0, wr_err}, 32'd1);
        cycle("rsvd 2");
        check("rsvd pulse 2", {31'b0, wr_err}, 32'd1);
        set_wr(1'b0, 0, 2'b10, 32'h0); set_rd(0, 1'b1, 3); cycle("r3");
        check("rsvd err cleared", {31'b0, wr_err}, 32'd0);
        check("rsvd unchanged", rd_port(0), 32'hCAFEF00D);

        // Read hold while rd_en is low.
        set_rd(0, 1'b0, 3);
        set_wr(1'b1, 7, 2'b10, 32'h55); cycle("w7 55");
        set_wr(1'b0, 0, 2'b10, 32'h0); set_rd(0, 1'b1, 7); cycle("r7 55");
        check("hold initial", rd_port(0), 32'h55);
        set_rd(0, 1'b0, 7); set_wr(1'b1, 7, 2'b10, 32'h66); cycle("w7 66");
        check("hold during write", rd_port(0), 32'h55);
        set_wr(1'b0, 0, 2'b10, 32'h0); cycle("idle");
        check("hold idle", rd_port(0), 32'h55);
        set_rd(0, 1'b1, 7); cycle("r7 66");
        check("hold released", rd_port(0), 32'h66);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            set_wr(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                   2'($urandom_range(0, 3)), $urandom);
            for (int p = 0; p < NR; p++) begin
                // Bias reads toward the write address to exercise bypass.
                if ($urandom_range(0, 3) == 0) set_rd(p, 1'($urandom_range(0, 1)), int'(wr_addr));
                else set_rd(p, 1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)));
            end
            cycle($sformatf("rand %0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
